// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises fetch and data accesses onto one memory bus, data first.
// Define ARB_TIMEOUT_EN to abort a grant after TIMEOUT cycles without bus_ack (bus_err pulse).
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ice,
    input  logic [AW-1:0]   iaddr,
    output logic [DW-1:0]   inst,
    output logic            if_done,
    input  logic            dce,
    input  logic [AW-1:0]   daddr,
    input  logic [DW/8-1:0] we,
    input  logic [DW-1:0]   din,
    output logic [DW-1:0]   dm,
    output logic            mem_done,
    output logic            stall_o,
    output logic            bus_req,
    output logic [AW-1:0]   bus_addr,
    output logic [DW/8-1:0] bus_be,
    output logic            bus_we,
    output logic [DW-1:0]   bus_wdata,
    input  logic            bus_ack,
    input  logic [DW-1:0]   bus_rdata,
    output logic            bus_err
);
    typedef enum logic [1:0] {IDLE, GNT_D, GNT_I} state_t;
    state_t state, state_nx;
    logic tmo, fin, grant;
`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    assign tmo = state != IDLE && !bus_ack && cnt == CW'(TIMEOUT - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            bus_err <= 1'b0;
        end else begin
            cnt <= (state == IDLE || bus_ack) ? '0 : cnt + 1'b1;
            bus_err <= tmo;
        end
    end
`else
    assign tmo = 1'b0;
    assign bus_err = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    // the done cycle is spent in IDLE without granting so the requester can drop its level
    always_comb begin
        state_nx = state;
        if (state == IDLE) state_nx = (mem_done || if_done) ? IDLE : dce ? GNT_D : ice ? GNT_I : IDLE;
        else if (bus_ack || tmo) state_nx = IDLE;
    end
    always_comb begin
        fin = state != IDLE && (bus_ack || tmo);
        grant = state == IDLE && state_nx != IDLE;
        stall_o = (dce && !mem_done) || (ice && !if_done);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req <= 1'b0;
            bus_addr <= '0;
            bus_be <= '0;
            bus_we <= 1'b0;
            bus_wdata <= '0;
            inst <= '0;
            dm <= '0;
            if_done <= 1'b0;
            mem_done <= 1'b0;
        end else begin
            mem_done <= fin && state == GNT_D;
            if_done <= fin && state == GNT_I;
            if (grant) begin
                bus_req <= 1'b1;
                bus_addr <= state_nx == GNT_D ? daddr : iaddr;
                bus_be <= state_nx == GNT_D ? we : '0;
                bus_we <= state_nx == GNT_D && |we;
                bus_wdata <= state_nx == GNT_D ? din : '0;
            end else if (fin) begin
                bus_req <= 1'b0;
            end
            if (fin && state == GNT_I) inst <= tmo ? '0 : bus_rdata;
            if (fin && state == GNT_D && (!bus_we || tmo)) dm <= tmo ? '0 : bus_rdata;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter.
module tb_mem_port_arbiter;
    logic clk = 0, rst = 1;
    logic ice = 0, dce = 0, bus_ack = 0;
    logic [31:0] iaddr = 0, daddr = 0, din = 0, bus_rdata = 0;
    logic [3:0] we = 0;
    logic [31:0] inst, dm, bus_addr, bus_wdata;
    logic [3:0] bus_be;
    logic if_done, mem_done, stall_o, bus_req, bus_we, bus_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .ice(ice), .iaddr(iaddr), .inst(inst), .if_done(if_done),
        .dce(dce), .daddr(daddr), .we(we), .din(din), .dm(dm), .mem_done(mem_done),
        .stall_o(stall_o), .bus_req(bus_req), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .bus_err(bus_err)
    );

    typedef struct {
        bit is_d;
        bit tmo;
        logic [31:0] val;
        logic [31:0] addr;
        logic [3:0] be;
        logic w;
        logic [31:0] wdata;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    int vectors = 0, miscompares = 0;
    int ack_dly = 0, wait_cnt = 0;
    bit ack_block = 0, stray = 0, req_prev = 0;
    int done_seen = 0, req_windows = 0, gnt_cycles = 0;
    logic [31:0] ack_addr = 0, ack_wdata = 0;
    logic [3:0] ack_be = 0;
    logic ack_we = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(logic [31:0] a);
        case (a)
            32'h40:  return 32'h2408_0005;
            32'h44:  return 32'h8C09_0010;
            32'h100: return 32'hDEAD_BEEF;
            default: return 32'h1357_9BDF;
        endcase
    endfunction

    task automatic push(bit is_d, bit t, logic [31:0] val, logic [31:0] addr, logic [3:0] be, logic w, logic [31:0] wd);
        exp_t e;
        e.is_d = is_d; e.tmo = t; e.val = val; e.addr = addr; e.be = be; e.w = w; e.wdata = wd;
        sb.push_back(e);
    endtask

    // memory responder: acks ack_dly cycles after bus_req rises
    always @(negedge clk) begin
        bus_ack = 0;
        if (bus_req && !ack_block) begin
            if (wait_cnt == ack_dly) begin
                bus_ack = 1;
                bus_rdata = mem_rd(bus_addr);
                ack_addr = bus_addr; ack_be = bus_be; ack_we = bus_we; ack_wdata = bus_wdata;
                wait_cnt = 0;
            end else wait_cnt++;
        end else begin
            wait_cnt = 0;
            if (stray && !bus_req) begin
                bus_ack = 1;
                bus_rdata = 32'hFFFF_FFFF;
            end
        end
    end

    always @(negedge clk) begin
        if (bus_req && !req_prev) req_windows++;
        if (bus_req) gnt_cycles++;
        req_prev = bus_req;
        if (mem_done || if_done) begin
            done_seen++;
            if (sb.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL unexpected_done: got mem_done=%0b if_done=%0b expected none", mem_done, if_done);
            end else begin
                mon_e = sb.pop_front();
                chk("done_kind", {31'b0, mem_done}, {31'b0, mon_e.is_d});
                chk("capture", mon_e.is_d ? dm : inst, mon_e.val);
                chk("bus_err", {31'b0, bus_err}, {31'b0, mon_e.tmo});
                if (!mon_e.tmo) begin
                    chk("bus_addr", ack_addr, mon_e.addr);
                    chk("bus_be", {28'b0, ack_be}, {28'b0, mon_e.be});
                    chk("bus_we", {31'b0, ack_we}, {31'b0, mon_e.w});
                    if (mon_e.w) chk("bus_wdata", ack_wdata, mon_e.wdata);
                end
            end
        end
    end

    task automatic serve();
        int n = 0;
        while ((dce || ice) && n < 200) begin
            @(negedge clk);
            n++;
            chk("stall_o", {31'b0, stall_o}, {31'b0, (dce && !mem_done) || (ice && !if_done)});
            if (mem_done) dce = 0;
            if (if_done) ice = 0;
        end
        if (dce || ice) begin
            vectors++; miscompares++;
            $display("FAIL serve_timeout: got requests pending after %0d cycles expected done", n);
            dce = 0; ice = 0;
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        int d0;
        repeat (3) @(negedge clk);
        chk("rst_bus_req", {31'b0, bus_req}, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_inst", inst, 0);
        chk("rst_dm", dm, 0);
        chk("rst_dones", {30'b0, if_done, mem_done}, 0);
        chk("rst_bus_err", {31'b0, bus_err}, 0);
        rst = 0;
        @(negedge clk);
        // fetch only, ack two cycles after request
        ack_dly = 2; req_windows = 0;
        push(0, 0, 32'h2408_0005, 32'h40, 4'b0000, 1'b0, 0);
        iaddr = 32'h40; ice = 1;
        serve();
        chk("t1_windows", req_windows, 1);
        // collision: data then fetch
        ack_dly = 0; req_windows = 0;
        push(1, 0, 32'hDEAD_BEEF, 32'h100, 4'b0000, 1'b0, 0);
        push(0, 0, 32'h8C09_0010, 32'h44, 4'b0000, 1'b0, 0);
        daddr = 32'h100; we = 0; dce = 1; iaddr = 32'h44; ice = 1;
        serve();
        chk("t2_windows", req_windows, 2);
        // byte store leaves dm at the last load
        push(1, 0, 32'hDEAD_BEEF, 32'h104, 4'b0010, 1'b1, 32'h0000_AB00);
        daddr = 32'h104; we = 4'b0010; din = 32'h0000_AB00; dce = 1;
        serve();
        we = 0;
        // reset mid-grant
        ack_block = 1; iaddr = 32'h200; ice = 1;
        n = 0;
        while (!bus_req && n < 20) begin @(negedge clk); n++; end
        chk("t4_granted", {31'b0, bus_req}, 1);
        rst = 1;
        #1;
        chk("t4_bus_req", {31'b0, bus_req}, 0);
        chk("t4_bus_addr", bus_addr, 0);
        chk("t4_inst", inst, 0);
        chk("t4_dm", dm, 0);
        ice = 0; ack_block = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        push(0, 0, 32'h2408_0005, 32'h40, 4'b0000, 1'b0, 0);
        iaddr = 32'h40; ice = 1;
        serve();
        // stray ack in IDLE
        d0 = done_seen;
        stray = 1;
        repeat (3) @(negedge clk);
        stray = 0;
        repeat (2) @(negedge clk);
        chk("t5_no_done", done_seen, d0);
        chk("t5_inst", inst, 32'h2408_0005);
        chk("t5_dm", dm, 0);
`ifdef ARB_TIMEOUT_EN
        ack_block = 1; gnt_cycles = 0;
        push(1, 1, 32'h0, 32'h100, 4'b0000, 1'b0, 0);
        daddr = 32'h100; dce = 1;
        serve();
        chk("t6_tmo_cycles", gnt_cycles, 4);
        ack_block = 0; ack_dly = 3; gnt_cycles = 0;
        push(1, 0, 32'hDEAD_BEEF, 32'h100, 4'b0000, 1'b0, 0);
        dce = 1;
        serve();
        chk("t6_ack_cycles", gnt_cycles, 4);
`endif
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
